dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Sequencer and arbiter for the single data-memory port. It shares the port between the pipeline MEM stage (core) and a host/loader requester. Each access is issued to memory as a one-cycle strobe, and the block waits out the fixed read latency before returning data. While the core's access is outstanding, the block drives a stall to the pipeline. Sits between EXMEM/MEMWB and data_memory.

## Interface
- `RD_LAT`, 1: cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..8.
- `STARVE_LIM`, 4: number of consecutive arbitrations the host may lose before it is forced to win; legal range 1..15.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `core_req` in 1: core access request; held stable until `core_done`.
- `core_we` in 1: core write (1) or read (0).
- `core_addr` in 64: core byte address.
- `core_wdata` in 64: core write data.
- `core_rdata` out 64: read data; valid while `core_done` is high for a read.
- `core_done` out 1: one-cycle completion pulse for the core.
- `core_stall` out 1: equals `core_req & ~core_done` (combinational); freezes PC, IFID and pipeline.
- `host_req`, `host_we`, `host_addr` (64), `host_wdata` (64) in: host request, same semantics as the core inputs.
- `host_rdata` out 64 / `host_done` out 1: same semantics as `core_rdata` / `core_done`.
- `mem_en` out 1: one-cycle access strobe to data_memory.
- `mem_we` out 1: write enable to data_memory.
- `mem_addr` out 64 / `mem_wdata` out 64: access address and write data to data_memory.
- `mem_rdata` in 64: data_memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- **IDLE:** if any request is present, latch the winner's id, we, addr and wdata, then go to ISSUE. With no request, stay in IDLE.
- **ISSUE:** `mem_en` = 1, with `mem_we`/`mem_addr`/`mem_wdata` driven from the latched values.
  - Write: go to DONE.
  - Read: load `cnt` = `RD_LAT` - 1 and go to WAIT.
- **WAIT:**
  - If `cnt` == 0: capture `mem_rdata` into the winner's rdata register and go to DONE.
  - Else: decrement `cnt` and stay in WAIT.
- **DONE:**
  - Assert the winner's done pulse for one cycle.
  - Go to IDLE; no arbitration occurs in this cycle.
  - The finished requester may present its next request from the following cycle.
- **Arbitration:** the core has fixed priority. The host wins only when the core is idle, or when the starvation guard forces it (see Configuration).
- **Simultaneous requests:** exactly one requester is granted; the loser's request stays pending. The loser is not acknowledged until its own done pulse.
- **Withdrawing a request mid-transaction** is a protocol violation. The transaction completes anyway and the done pulse still fires.
- **Read data registers:** `core_rdata`/`host_rdata` hold their last captured value until the next read by the same requester. Writes do not alter them.
- **Addresses and data** pass through unmodified; there is no alignment check.

## Timing
- **Reset values:** `mem_en`, `mem_we`, `core_done` and `host_done` are 0. `mem_addr`, `mem_wdata`, `core_rdata` and `host_rdata` are 0. State = IDLE and `cnt` = 0. `core_stall` follows `core_req`.
- **Reset mid-access:** the FSM is forced to IDLE immediately. The in-flight access is dropped, with no done pulse and no capture.
- **Write latency:** request seen in cycle c0; `mem_en` in c1; done in c2. The core stalls during c0 and c1.
- **Read latency:** request in c0; `mem_en` in c1; WAIT for `RD_LAT` cycles; done in c2+`RD_LAT`. The core stalls for 2+`RD_LAT` cycles.
- **Throughput:** minimum request-to-request spacing is 3 cycles for writes and 3+`RD_LAT` for reads.
- **Outputs:** all outputs are registered except `core_stall`.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter `host_wait` increments on each IDLE arbitration the host loses while `host_req` is high.
  - When `host_wait` == `STARVE_LIM`, the host wins the next arbitration even if `core_req` is high.
  - `host_wait` clears to 0 when the host is granted, and on reset.
- `DMEM_ARB_STARVE_GUARD_EN` undefined: strict core priority; the counter is absent, and the host can starve indefinitely.

## Test plan
- **Core write:** after reset, core writes 0xDEAD_BEEF to 0x10 (`RD_LAT`=1) -> `mem_en`/`mem_we` high in c1 with `mem_addr`=0x10; `core_done` in c2; `core_stall` high in c0–c1 only.
- **Core read:** core reads 0x10 with `RD_LAT`=3 and memory returning 0xDEAD_BEEF -> `core_done` in c5 with `core_rdata`=0xDEAD_BEEF; `core_stall` high in c0–c4.
- **Simultaneous requests:** core read of 0x8 and host write of 0x20 asserted in the same cycle -> core is served first (done at c3 for `RD_LAT`=1); host `mem_en` in c5; `host_done` in c6.
- **Starvation guard on:** with the guard defined and `STARVE_LIM`=2, core requests back-to-back while `host_req` is held high -> host is granted on the 3rd arbitration. Undefined -> the host is never granted while the core keeps requesting.
- **Reset mid-read:** assert `reset` during WAIT of a `RD_LAT`=4 read -> no done pulse; all outputs go to 0. After release, a new core read completes normally.
- **Idle:** no requests for 10 cycles -> `mem_en` stays 0 and the state stays in IDLE.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Single data-memory port sequencer shared by the pipeline MEM stage (core) and a host/loader.
// Optional host starvation guard is enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter #(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [63:0] core_addr,
    input  logic [63:0] core_wdata,
    output logic [63:0] core_rdata,
    output logic        core_done,
    output logic        core_stall,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [63:0] host_addr,
    input  logic [63:0] host_wdata,
    output logic [63:0] host_rdata,
    output logic        host_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD     = 4'(RD_LAT - 1);
    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIM);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        id_host_q, id_host_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] core_rdata_q, core_rdata_d;
    logic [63:0] host_rdata_q, host_rdata_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic        core_done_q, core_done_d;
    logic        host_done_q, host_done_d;
    logic        starve_force_s;
    logic        grant_host_s;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic [3:0]  host_wait_q, host_wait_d;

    assign starve_force_s = (host_wait_q == STARVE_LIM_C);
`else
    assign starve_force_s = 1'b0;
`endif

    // Core has fixed priority unless the host has lost too many arbitrations in a row
    assign grant_host_s = host_req & (~core_req | starve_force_s);

    // Next-state, transaction latch and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        id_host_d    = id_host_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_rdata_d = core_rdata_q;
        host_rdata_d = host_rdata_q;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        host_wait_d  = host_wait_q;
`endif
        case (state_q)
            IDLE: begin
                if (core_req | host_req) begin
                    id_host_d = grant_host_s;
                    we_d      = grant_host_s ? host_we    : core_we;
                    addr_d    = grant_host_s ? host_addr  : core_addr;
                    wdata_d   = grant_host_s ? host_wdata : core_wdata;
                    state_d   = ISSUE;
`ifdef DMEM_ARB_STARVE_GUARD_EN
                    if (grant_host_s) begin
                        host_wait_d = 4'd0;
                    end else if (host_req) begin
                        host_wait_d = host_wait_q + 4'd1;
                    end else begin
                        host_wait_d = host_wait_q;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (id_host_q) begin
                        host_rdata_d = mem_rdata;
                    end else begin
                        core_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are computed from the next state so they coincide with ISSUE/DONE
        mem_en_d    = (state_d == ISSUE);
        mem_we_d    = (state_d == ISSUE) & we_d;
        core_done_d = (state_d == DONE) & ~id_host_d;
        host_done_d = (state_d == DONE) & id_host_d;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            id_host_q    <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            core_rdata_q <= 64'd0;
            host_rdata_q <= 64'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            core_done_q  <= 1'b0;
            host_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            id_host_q    <= id_host_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rdata_q <= core_rdata_d;
            host_rdata_q <= host_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            core_done_q  <= core_done_d;
            host_done_q  <= host_done_d;
        end
    end

`ifdef DMEM_ARB_STARVE_GUARD_EN
    // Count of consecutive host arbitration losses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_wait_q <= 4'd0;
        end else begin
            host_wait_q <= host_wait_d;
        end
    end
`endif

    assign core_rdata = core_rdata_q;
    assign host_rdata = host_rdata_q;
    assign core_done  = core_done_q;
    assign host_done  = host_done_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign core_stall = core_req & ~core_done_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: transaction-level model, memory responder, directed and random traffic.
module tb_dmem_port_arbiter;

    localparam int RD_LAT     = 3;
    localparam int STARVE_LIM = 2;

    logic        clk;
    logic        reset;
    logic        core_req, core_we, host_req, host_we;
    logic [63:0] core_addr, core_wdata, host_addr, host_wdata;
    logic [63:0] core_rdata, host_rdata;
    logic        core_done, core_stall, host_done;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    dmem_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_done(core_done), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_done(host_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n = 0;

    // transaction-level model state
    int          free_at, t_en, t_done, host_wait, rd_due;
    logic        t_host, t_we;
    logic [63:0] t_addr, t_wdata, t_rdata, rd_pend;
    logic [63:0] exp_core_rdata, exp_host_rdata;
    logic [63:0] mdl_mem  [16];
    logic [63:0] resp_mem [16];
    bit          exp_cdone, exp_hdone;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    task automatic model_reset();
        free_at = 0; t_en = -1; t_done = -1; rd_due = -1; host_wait = 0;
        t_host = 1'b0; t_we = 1'b0;
        exp_core_rdata = 64'd0; exp_host_rdata = 64'd0;
    endtask

    task automatic set_core(input logic we, input logic [63:0] a, input logic [63:0] d);
        core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_host(input logic we, input logic [63:0] a, input logic [63:0] d);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    endtask

    // One clock cycle: arbitrate in the model, advance, respond as memory, compare everything.
    task automatic cycle_end();
        bit force_h;
        force_h = 1'b0;
        if (!reset && n >= free_at && (core_req || host_req)) begin
`ifdef DMEM_ARB_STARVE_GUARD_EN
            force_h = (host_wait == STARVE_LIM);
`endif
            t_host = host_req && (!core_req || force_h);
            if (t_host) host_wait = 0;
            else if (host_req) host_wait++;
            t_we    = t_host ? host_we    : core_we;
            t_addr  = t_host ? host_addr  : core_addr;
            t_wdata = t_host ? host_wdata : core_wdata;
            t_en    = n + 1;
            t_done  = n + 2 + (t_we ? 0 : RD_LAT);
            free_at = t_done + 1;
        end
        @(posedge clk);
        n++;
        @(negedge clk);
        if (mem_en) begin
            if (mem_we) resp_mem[mem_addr[6:3]] = mem_wdata;
            else begin
                rd_pend = resp_mem[mem_addr[6:3]];
                rd_due  = n + RD_LAT;
            end
        end
        mem_rdata = (n == rd_due) ? rd_pend : {$urandom, $urandom};

        exp_cdone = (n == t_done) && !t_host;
        exp_hdone = (n == t_done) && t_host;
        if (n == t_en) begin
            if (t_we) mdl_mem[t_addr[6:3]] = t_wdata;
            else t_rdata = mdl_mem[t_addr[6:3]];
        end
        if (n == t_done && !t_we) begin
            if (t_host) exp_host_rdata = t_rdata;
            else exp_core_rdata = t_rdata;
        end
        chk("mem_en", mem_en, 64'(n == t_en));
        if (n == t_en) begin
            chk("mem_we", mem_we, 64'(t_we));
            chk("mem_addr", mem_addr, t_addr);
            if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
        end
        chk("core_done", core_done, 64'(exp_cdone));
        chk("host_done", host_done, 64'(exp_hdone));
        chk("core_rdata", core_rdata, exp_core_rdata);
        chk("host_rdata", host_rdata, exp_host_rdata);
        chk("core_stall", core_stall, 64'(core_req && !exp_cdone));
        if (exp_cdone) core_req = 1'b0;
        if (exp_hdone) host_req = 1'b0;
    endtask

    initial begin
        int c_done, h_en, h_done, core_p, host_p;
        core_req = 1'b0; core_we = 1'b0; core_addr = 64'd0; core_wdata = 64'd0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 64'd0; host_wdata = 64'd0;
        mem_rdata = 64'd0;
        for (int i = 0; i < 16; i++) begin
            mdl_mem[i]  = 64'hA5A5_0000_0000_0000 | 64'(i);
            resp_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        end
        reset = 1'b1;
        model_reset();
        repeat (3) cycle_end();
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_we", mem_we, 64'd0);
        chk("rst_core_rdata", core_rdata, 64'd0);
        reset = 1'b0;
        cycle_end();

        // core write: mem_en in c1, done in c2
        set_core(1'b1, 64'h10, 64'hDEAD_BEEF);
        cycle_end();
        chk("wr_c1_en", mem_en, 64'd1);
        chk("wr_c1_we", mem_we, 64'd1);
        chk("wr_c1_addr", mem_addr, 64'h10);
        chk("wr_c1_stall", core_stall, 64'd1);
        cycle_end();
        chk("wr_c2_done", core_done, 64'd1);
        cycle_end();

        // core read: done in c2+RD_LAT, stall through c1+RD_LAT
        set_core(1'b0, 64'h10, 64'd0);
        repeat (1 + RD_LAT) cycle_end();
        chk("rd_last_stall", core_stall, 64'd1);
        chk("rd_not_done_yet", core_done, 64'd0);
        cycle_end();
        chk("rd_done", core_done, 64'd1);
        chk("rd_data", core_rdata, 64'hDEAD_BEEF);
        cycle_end();

        // simultaneous core read and host write
        set_core(1'b0, 64'h8, 64'd0);
        set_host(1'b1, 64'h20, 64'h1234_5678_9ABC_DEF0);
        c_done = -1; h_en = -1; h_done = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle_end();
            if (core_done && c_done < 0) c_done = i;
            if (mem_en && mem_we && h_en < 0) h_en = i;
            if (host_done && h_done < 0) h_done = i;
        end
        chk("sim_core_done_cyc", 64'(c_done), 64'(2 + RD_LAT));
        chk("sim_host_en_cyc", 64'(h_en), 64'(4 + RD_LAT));
        chk("sim_host_done_cyc", 64'(h_done), 64'(5 + RD_LAT));
        chk("sim_core_rdata", core_rdata, 64'hA5A5_0000_0000_0001);

        // idle: no strobe for 10 cycles
        for (int i = 0; i < 10; i++) begin
            cycle_end();
            chk("idle_en", mem_en, 64'd0);
        end

        // starvation: host write held while core writes back-to-back
        set_host(1'b1, 64'h28, 64'h5555_AAAA_5555_AAAA);
        set_core(1'b1, 64'h30, 64'h1);
        h_done = -1;
        for (int i = 1; i <= 30; i++) begin
            cycle_end();
            if (host_done && h_done < 0) h_done = i;
            if (!core_req) set_core(1'b1, 64'h30 + 64'(i), {$urandom, $urandom});
        end
`ifdef DMEM_ARB_STARVE_GUARD_EN
        chk("starve_host_done_cyc", 64'(h_done), 64'd8);
`else
        chk("starve_host_never", 64'(h_done), 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        for (int i = 0; i < 40; i++) cycle_end();

        // reset in the middle of a read
        set_core(1'b0, 64'h18, 64'd0);
        repeat (3) cycle_end();
        reset = 1'b1;
        core_req = 1'b0;
        model_reset();
        #1;
        chk("mrst_en", mem_en, 64'd0);
        chk("mrst_done", core_done, 64'd0);
        chk("mrst_rdata", core_rdata, 64'd0);
        chk("mrst_addr", mem_addr, 64'd0);
        repeat (2) cycle_end();
        reset = 1'b0;
        set_core(1'b0, 64'h10, 64'd0);
        repeat (2 + RD_LAT) cycle_end();
        chk("mrst_after_done", core_done, 64'd1);
        chk("mrst_after_data", core_rdata, 64'hDEAD_BEEF);
        cycle_end();

        // randomized traffic with changing request densities and occasional resets
        for (int i = 0; i < 4000; i++) begin
            case (i / 1000)
                0: begin core_p = 30;  host_p = 30;  end
                1: begin core_p = 90;  host_p = 20;  end
                2: begin core_p = 100; host_p = 100; end
                default: begin core_p = 10; host_p = 90; end
            endcase
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                core_req = 1'b0;
                host_req = 1'b0;
                model_reset();
                cycle_end();
                reset = 1'b0;
            end
            if (!core_req && $urandom_range(0, 99) < core_p)
                set_core(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
            if (!host_req && $urandom_range(0, 99) < host_p)
                set_host(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
            cycle_end();
        end
        core_req = 1'b0;
        host_req = 1'b0;
        repeat (20) cycle_end();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
